// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: MODE encodings and delay constants for univ_shift_reg.
package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROTL = 3'b100,
        MODE_ROTR = 3'b101,
        MODE_ASHR = 3'b110,
        MODE_SCLR = 3'b111
    } mode_e;

    // Timing-lab delay contributions, summed on every output when delays are enabled.
    localparam int TIME_DELAY_3 = 2;
    localparam int FAN_OUT_1    = 1;
    localparam int PRIMARY_OUT  = 1;

endpackage

// File: rtl/univ_shift_reg_dff_clr.sv
// dff_clr: 1-bit D flip-flop with asynchronous active-high clear and complementary outputs.
// Ports: CLK clock, D data, CLR async clear, Q state, Q_BAR ~Q.
module dff_clr (
    input  logic CLK,
    input  logic D,
    input  logic CLR,
    output logic Q,
    output logic Q_BAR
);

    logic q_q;

    always_ff @(posedge CLK or posedge CLR)
        if (CLR) q_q <= 1'b0;
        else     q_q <= D;

    assign Q     = q_q;
    assign Q_BAR = ~q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register (hold/load/shift/rotate/ashr/sclr).
// Ports: CLK clock, CLR async clear, EN enable, MODE op select, D load data,
//        SIL/SIR serial inputs, Q state, Q_BAR ~Q, SOL = Q[WIDTH-1], SOR = Q[0].
// Define UNIV_SHREG_DELAY_EN to drive all outputs through an inertial lab delay.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_BAR,
    output logic             SOL,
    output logic             SOR
);

    logic [WIDTH-1:0] q_d, q_q, qb_q;

    always_comb begin
        q_d = q_q;
        if (EN) begin
            case (MODE)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = D;
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], SIL};
                MODE_SHR:  q_d = {SIR, q_q[WIDTH-1:1]};
                MODE_ROTL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROTR: q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ASHR: q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                MODE_SCLR: q_d = '0;
                // Only reachable with X/Z on MODE; propagate the unknown.
                default:   q_d = 'x;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_clr u_dff (
            .CLK  (CLK),
            .D    (q_d[i]),
            .CLR  (CLR),
            .Q    (q_q[i]),
            .Q_BAR(qb_q[i])
        );
    end

`ifdef UNIV_SHREG_DELAY_EN
    localparam int DLY = TIME_DELAY_3 + FAN_OUT_1 + PRIMARY_OUT;
    assign #(DLY) Q     = q_q;
    assign #(DLY) Q_BAR = qb_q;
    assign #(DLY) SOL   = q_q[WIDTH-1];
    assign #(DLY) SOR   = q_q[0];
`else
    assign Q     = q_q;
    assign Q_BAR = qb_q;
    assign SOL   = q_q[WIDTH-1];
    assign SOR   = q_q[0];
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed bench with an arithmetic reference model checked every cycle.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'h00;
    logic       sil = 1'b0;
    logic       sir = 1'b0;
    logic [7:0] q, q_bar;
    logic       sol, sor;
    logic [7:0] m = 8'h00;
    int         checks = 0;
    int         errors = 0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .CLK  (clk),
        .CLR  (clr),
        .EN   (en),
        .MODE (mode),
        .D    (d),
        .SIL  (sil),
        .SIR  (sir),
        .Q    (q),
        .Q_BAR(q_bar),
        .SOL  (sol),
        .SOR  (sor)
    );

    always #10 clk = ~clk;

    // Reference model: each mode expressed as plain shift/or arithmetic on an 8-bit value.
    always @(posedge clk or posedge clr)
        if (clr) m <= 8'h00;
        else if (en)
            case (mode)
                3'd1: m <= d;
                3'd2: m <= (m << 1) | 8'(sil);
                3'd3: m <= (m >> 1) | (8'(sir) << 7);
                3'd4: m <= (m << 1) | (m >> 7);
                3'd5: m <= (m >> 1) | (m << 7);
                3'd6: m <= 8'($signed(m) >>> 1);
                3'd7: m <= 8'h00;
                default: m <= m;
            endcase

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_q", q, m);
        chk("model_qbar", q_bar, ~m);
        chk("model_sol", {7'd0, sol}, {7'd0, m[7]});
        chk("model_sor", {7'd0, sor}, {7'd0, m[0]});
    end

    // Called at a negedge: set inputs, then wait past one rising edge to the next negedge.
    task automatic step(input logic e, input logic [2:0] md, input logic [7:0] dd,
                        input logic sl, input logic sr);
        en = e; mode = md; d = dd; sil = sl; sir = sr;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b1011_0010;
        repeat (2) @(negedge clk);
        chk("rst_q", q, 8'h00);
        chk("rst_qbar", q_bar, 8'hFF);
        chk("rst_taps", {6'd0, sol, sor}, 8'h00);
        clr = 1'b0;
        step(1, 3'd1, 8'hA5, 0, 0);
        chk("load_a5", q, 8'hA5);
        #2 clr = 1'b1;
        #6;
        chk("async_clr_q", q, 8'h00);
        chk("async_clr_qbar", q_bar, 8'hFF);
        @(negedge clk);
        step(1, 3'd1, 8'hFF, 0, 0);
        step(1, 3'd1, 8'hFF, 0, 0);
        chk("edges_in_clr", q, 8'h00);
        clr = 1'b0;
        step(1, 3'd1, 8'h3C, 0, 0);
        chk("first_after_clr", q, 8'h3C);
        step(1, 3'd0, 8'hFF, 1, 1);
        chk("hold", q, 8'h3C);
        step(1, 3'd7, 8'hFF, 1, 1);
        chk("sclr", q, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 3'd1, 8'h96, 0, 0);
            chk("en0_hold", q, 8'h00);
        end
        step(1, 3'd1, 8'h96, 0, 0);
        chk("load_96", q, 8'h96);
        chk("load_96_qbar", q_bar, 8'h69);
        step(0, 3'd7, 8'h00, 0, 0);
        chk("en0_sclr", q, 8'h96);
        step(1, 3'd7, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 3'd2, 8'h00, pat[7-i], 0);
            chk("sol_latency", {7'd0, sol}, {7'd0, (i == 7)});
        end
        chk("shl_b2", q, 8'hB2);
        step(1, 3'd7, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 3'd3, 8'h00, 0, pat[7-i]);
            chk("sor_latency", {7'd0, sor}, {7'd0, (i == 7)});
        end
        chk("shr_4d", q, 8'h4D);
        step(1, 3'd1, 8'h81, 0, 0);
        step(1, 3'd4, 8'h00, 0, 0);
        chk("rotl_03", q, 8'h03);
        step(1, 3'd5, 8'h00, 0, 0);
        chk("rotr_81", q, 8'h81);
        step(1, 3'd5, 8'h00, 0, 0);
        chk("rotr_c0", q, 8'hC0);
        step(1, 3'd1, 8'h90, 0, 0);
        step(1, 3'd6, 8'h00, 0, 0);
        chk("ashr_c8", q, 8'hC8);
        step(1, 3'd6, 8'h00, 0, 0);
        chk("ashr_e4", q, 8'hE4);
        step(1, 3'd7, 8'h00, 0, 0);
        chk("sclr_after_ashr", q, 8'h00);
        step(1, 3'd1, 8'h10, 0, 0);
        step(1, 3'd6, 8'h00, 1, 1);
        chk("ashr_ignores_sir", q, 8'h08);
        step(1, 3'd1, 8'h55, 0, 0);
        en = 1'b1; mode = 3'd1; d = 8'hFF;
        @(posedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("collision_q", q, 8'h00);
        chk("collision_qbar", q_bar, 8'hFF);
        clr = 1'b0;
        step(1, 3'd1, 8'h5A, 0, 0);
        chk("after_collision", q, 8'h5A);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
